// File: rtl/move_resolver_pkg.sv
// Shared encodings for the lane-dodging car game: move codes and game state.
package move_pkg;

    // Player request / tick outcome encoding
    typedef enum logic [1:0] {
        MV_NONE  = 2'b00,
        MV_RIGHT = 2'b01,
        MV_LEFT  = 2'b10,
        MV_HIT   = 2'b11
    } move_t;

    // Game state
    typedef enum logic [1:0] {
        ALIVE,
        IMMUNE,
        OVER
    } state_t;

    // Only a real left/right step may be latched as a pending move
    function automatic logic isStep(input move_t m);
        return (m == MV_LEFT) || (m == MV_RIGHT);
    endfunction

endpackage

// File: rtl/move_resolver_if.sv
// Road/player/result bundle between the game front end and the move resolver.
interface move_resolver_if #(
    parameter int LANES = 6
);
    localparam int PW = $clog2(LANES);

    logic [LANES-1:0] next_row;
    logic [LANES-1:0] head_row;
    logic [1:0]       attempt_move;
    logic [PW-1:0]    position;
    logic [1:0]       move_result;
    logic             result_valid;
    logic [3:0]       lives;
    logic             immune;
    logic             game_over;

    modport master (
        output next_row, head_row, attempt_move,
        input  position, move_result, result_valid, lives, immune, game_over
    );

    modport slave (
        input  next_row, head_row, attempt_move,
        output position, move_result, result_valid, lives, immune, game_over
    );

endinterface

// File: rtl/move_resolver_tick_gen.sv
// Game tick generator: free-running 0..TICK_DIV-1 counter, strobe on the last count.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    // Count clk cycles, wrapping at the end of each tick window
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (tick)
            count <= '0;
        else
            count <= count + CW'(1);
    end

endmodule

// File: rtl/move_resolver.sv
// Resolves the player's lane change once per game tick: collision, immunity and lives.
module move_resolver
    import move_pkg::*;
#(
    parameter int LANES        = 6,
    parameter int IMMUNE_TICKS = 3,
    parameter int TICK_DIV     = 50_000_000,
    parameter int LIVES        = 3,
    parameter int START_POS    = 2
) (
    input  logic            clk,
    input  logic            rst,
    move_resolver_if.slave  bus
);
    localparam int PW = $clog2(LANES);
    localparam logic [PW-1:0] LAST_LANE = PW'(LANES - 1);

    logic          tick;
    state_t        state;
    move_t         pend;
    move_t         req;
    logic          reqValid;
    logic [7:0]    immCnt;
    logic [PW-1:0] posQ;
    logic [3:0]    livesQ;
    move_t         resQ;
    logic          validQ;
    logic [PW-1:0] target;
    logic          moved;
    logic          hit;
    move_t         stepResult;

    tick_gen #(.TICK_DIV(TICK_DIV)) uTick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign req      = move_t'(bus.attempt_move);
    assign reqValid = isStep(req);

    // Target lane for the pending move; edge moves are blocked, never wrapped
    always_comb begin
        target = posQ;
        case (pend)
            MV_LEFT:  if (posQ != LAST_LANE) target = posQ + PW'(1);
            MV_RIGHT: if (posQ != '0)        target = posQ - PW'(1);
            default:  target = posQ;
        endcase
        moved      = (target != posQ);
        hit        = bus.next_row[target] | (moved & bus.head_row[target]);
        stepResult = moved ? pend : MV_NONE;
    end

    // Game FSM: move latch, per-tick evaluation and registered results
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ALIVE;
            pend   <= MV_NONE;
            immCnt <= '0;
            posQ   <= PW'(START_POS);
            livesQ <= 4'(LIVES);
            resQ   <= MV_NONE;
            validQ <= 1'b0;
        end else begin
            validQ <= 1'b0;
            if (state == OVER) begin
                pend <= MV_NONE;
            end else if (tick) begin
                // The latched move is consumed; a request on this cycle opens the next window
                pend   <= reqValid ? req : MV_NONE;
                validQ <= 1'b1;
                case (state)
                    ALIVE: begin
                        if (hit) begin
                            resQ   <= MV_HIT;
                            livesQ <= livesQ - 4'd1;
                            immCnt <= '0;
                            state  <= (livesQ == 4'd1) ? OVER : IMMUNE;
                        end else begin
                            posQ <= target;
                            resQ <= stepResult;
                        end
                    end
                    IMMUNE: begin
                        posQ <= target;
                        resQ <= stepResult;
                        if (immCnt == 8'(IMMUNE_TICKS - 1)) begin
                            state  <= ALIVE;
                            immCnt <= '0;
                        end else begin
                            immCnt <= immCnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (pend == MV_NONE && reqValid) begin
                pend <= req;
            end
        end
    end

    assign bus.position     = posQ;
    assign bus.move_result  = resQ;
    assign bus.result_valid = validQ;
    assign bus.lives        = livesQ;
    assign bus.immune       = (state == IMMUNE);
    assign bus.game_over    = (state == OVER);

endmodule

// File: tb/tb_move_resolver.sv
// Self-checking bench for move_resolver: game-level reference model plus directed scenarios.
module tb_move_resolver;
    localparam int LANES = 6;
    localparam int TD    = 8;
    localparam int IMM   = 3;
    localparam int LV    = 3;
    localparam int SP    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    move_resolver_if #(.LANES(LANES)) bus ();

    move_resolver #(
        .LANES(LANES), .IMMUNE_TICKS(IMM), .TICK_DIV(TD), .LIVES(LV), .START_POS(SP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference game model: cycle count since reset, lives, remaining immune ticks
    int mCyc = 0, mPos = SP, mLives = LV, mImm = 0, mDir = 0, mRes = 0;
    bit mOver = 0, mValid = 0;

    always @(posedge clk) begin
        int reqDir;
        int tgt;
        bit tickNow, mv, h;
        reqDir = (bus.attempt_move == 2'b10) ? 1 : (bus.attempt_move == 2'b01) ? -1 : 0;
        if (rst) begin
            mCyc = 0; mPos = SP; mLives = LV; mImm = 0; mDir = 0; mRes = 0;
            mOver = 0; mValid = 0;
        end else begin
            tickNow = (mCyc % TD) == TD - 1;
            mValid  = 0;
            if (!mOver && tickNow) begin
                tgt = mPos + mDir;
                if (tgt < 0 || tgt >= LANES) tgt = mPos;
                mv = (tgt != mPos);
                h  = (mImm == 0) && (bus.next_row[tgt] || (mv && bus.head_row[tgt]));
                if (h) begin
                    mLives--;
                    mRes = 3;
                    if (mLives == 0) mOver = 1;
                    else mImm = IMM;
                end else begin
                    mRes = !mv ? 0 : (mDir > 0) ? 2 : 1;
                    mPos = tgt;
                    if (mImm > 0) mImm--;
                end
                mValid = 1;
            end
            if (mOver) mDir = 0;
            else if (tickNow) mDir = reqDir;
            else if (mDir == 0) mDir = reqDir;
            mCyc++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (checkEn) begin
            chk("m_valid",     bus.result_valid, mValid);
            chk("m_position",  bus.position,     mPos);
            chk("m_lives",     bus.lives,        mLives);
            chk("m_immune",    bus.immune,       (mImm > 0) && !mOver);
            chk("m_game_over", bus.game_over,    mOver);
            chk("m_result",    bus.move_result,  mRes);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [1:0] mv);
        bus.attempt_move = mv;
        @(negedge clk);
        bus.attempt_move = 2'b00;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance to the next result strobe, giving up after a few tick windows
    task automatic waitValid(input string name);
        int n = 0;
        @(negedge clk);
        while (bus.result_valid !== 1'b1 && n < 3 * TD) begin
            @(negedge clk);
            n++;
        end
        if (bus.result_valid !== 1'b1) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int seen;
        bus.next_row     = '0;
        bus.head_row     = '0;
        bus.attempt_move = 2'b00;
        cycles(2);
        doReset();
        checkEn = 1'b1;
        chk("rst_position", bus.position, 2);
        chk("rst_lives",    bus.lives,    3);
        chk("rst_valid",    bus.result_valid, 0);

        // First request wins; the later opposite request is ignored
        cycles(2);
        pulse(2'b10);
        cycles(1);
        pulse(2'b01);
        waitValid("t1");
        chk("t1_result",   bus.move_result, 2'b10);
        chk("t1_position", bus.position,    3);

        pulse(2'b10); waitValid("t2");
        pulse(2'b10); waitValid("t3");
        chk("edge_pos", bus.position, 5);

        // Blocked left at the edge into an obstacle
        bus.next_row = 6'b100000;
        pulse(2'b10);
        waitValid("hit1");
        chk("hit1_result",   bus.move_result, 2'b11);
        chk("hit1_position", bus.position,    5);
        chk("hit1_lives",    bus.lives,       2);
        chk("hit1_immune",   bus.immune,      1);

        // Immunity lasts three ticks, then the full row hits again
        bus.next_row = 6'b111111;
        waitValid("imm1"); chk("imm1_immune", bus.immune, 1); chk("imm1_lives", bus.lives, 2);
        waitValid("imm2"); chk("imm2_immune", bus.immune, 1);
        waitValid("imm3"); chk("imm3_immune", bus.immune, 0); chk("imm3_lives", bus.lives, 2);
        waitValid("hit2");
        chk("hit2_result", bus.move_result, 2'b11);
        chk("hit2_lives",  bus.lives,       1);

        repeat (3) waitValid("imm");
        waitValid("hit3");
        chk("hit3_lives", bus.lives,     0);
        chk("hit3_over",  bus.game_over, 1);

        seen = 0;
        repeat (5 * TD) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) seen++;
        end
        chk("over_no_valid", seen, 0);

        bus.next_row = '0;
        doReset();
        chk("rerst_lives",    bus.lives,     3);
        chk("rerst_position", bus.position,  2);
        chk("rerst_over",     bus.game_over, 0);

        // Right edge is blocked; invalid 11 never latches
        pulse(2'b01); waitValid("r1"); chk("r1_position", bus.position, 1);
        pulse(2'b01); waitValid("r2"); chk("r2_position", bus.position, 0);
        pulse(2'b01); waitValid("r3");
        chk("r3_result",   bus.move_result, 2'b00);
        chk("r3_position", bus.position,    0);
        pulse(2'b11); waitValid("inv");
        chk("inv_result", bus.move_result, 2'b00);

        // Request only on the tick cycle seeds the following window
        doReset();
        cycles(7);
        bus.attempt_move = 2'b01;
        @(negedge clk);
        bus.attempt_move = 2'b00;
        chk("seed_valid",  bus.result_valid, 1);
        chk("seed_result", bus.move_result,  2'b00);
        waitValid("seed2");
        chk("seed2_result",   bus.move_result, 2'b01);
        chk("seed2_position", bus.position,    1);

        // Reset on a tick cycle while immune
        bus.next_row = 6'b000010;
        waitValid("hit4");
        chk("hit4_immune", bus.immune, 1);
        cycles(7);
        rst = 1'b1;
        @(negedge clk);
        chk("tickrst_valid",    bus.result_valid, 0);
        chk("tickrst_immune",   bus.immune,       0);
        chk("tickrst_lives",    bus.lives,        3);
        chk("tickrst_position", bus.position,     2);
        chk("tickrst_result",   bus.move_result,  2'b00);
        rst = 1'b0;
        bus.next_row = '0;
        cycles(2 * TD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/move_resolver.md
MOVE_RESOLVER -- requirements
Module: move_resolver

Interface
REQ-001 Parameter LANES, default 6: number of road lanes; legal range 2..32.
REQ-002 Parameter IMMUNE_TICKS, default 3: game ticks of collision immunity after a hit; legal range 1..255.
REQ-003 Parameter TICK_DIV, default 50_000_000: clk cycles per game tick; minimum 4.
REQ-004 Parameter LIVES, default 3: lives at reset; legal range 1..15.
REQ-005 Parameter START_POS, default 2: lane index at reset; must be < LANES.
REQ-006 clk  in  1  system clock; all logic on posedge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 next_row  in  LANES  obstacle occupancy of the row the car enters at the next tick; bit i = lane i.
REQ-009 head_row  in  LANES  obstacle occupancy of the car's current row.
REQ-010 attempt_move  in  2  player request: 00 none, 10 left (lane+1), 01 right (lane-1), 11 invalid.
REQ-011 position  out  $clog2(LANES)  current car lane.
REQ-012 move_result  out  2  last tick outcome: 00 stay, 10 moved left, 01 moved right, 11 hit.
REQ-013 result_valid  out  1  one-cycle strobe; move_result/position/lives updated this cycle.
REQ-014 lives  out  4  remaining lives.
REQ-015 immune  out  1  high while immunity is active.
REQ-016 game_over  out  1  high once lives reach 0.

Function
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick strobe SHALL be internal, high when count == TICK_DIV-1.
REQ-018 Move latch SHALL capture the first attempt_move of 10 or 01 in a tick window; later requests in the same window SHALL be ignored; 00 and 11 never latch.
REQ-019 On the tick cycle the latch SHALL be consumed and cleared; a valid request present on that same cycle SHALL seed the latch for the next window.
REQ-020 Evaluation SHALL occur on the tick cycle; outputs and result_valid SHALL be registered on the next clk edge (latency 1 cycle from tick strobe).
REQ-021 Target lane: left -> position+1 unless position == LANES-1; right -> position-1 unless position == 0; otherwise position (blocked edge move = stay).
REQ-022 State ALIVE, hit test: next_row[target] OR (move actually taken AND head_row[target]).
REQ-023 ALIVE with hit: move_result = 11, position unchanged, lives decrement by 1, go IMMUNE with immunity counter = 0; if lives becomes 0 go OVER instead.
REQ-024 ALIVE without hit: move_result = 00/10/01 per actual move taken, position = target.
REQ-025 State IMMUNE: no hit test; position = target, move_result per actual move; immunity counter increments each tick; after IMMUNE_TICKS ticks return to ALIVE on that tick.
REQ-026 State OVER: tick counter keeps running; no evaluation, latch held clear, result_valid low, all outputs frozen; exit only by rst.
REQ-027 immune SHALL equal (state == IMMUNE); game_over SHALL equal (state == OVER).
REQ-028 position SHALL never leave 0..LANES-1; no arithmetic wrap.

Reset
REQ-029 rst SHALL force: state ALIVE, tick counter 0, latch 00, immunity counter 0, position START_POS, lives LIVES, move_result 00, result_valid 0.
REQ-030 rst asserted mid-window or on a tick cycle SHALL win over every other update; no result_valid in that cycle.

Structure
REQ-031 Shared package move_pkg: move encodings (MV_NONE, MV_LEFT, MV_RIGHT, MV_HIT) and the state enum (ALIVE, IMMUNE, OVER).
REQ-032 Sub-module tick_gen (parameter TICK_DIV; ports clk, rst, tick) SHALL hold the tick counter.

Verification (TICK_DIV=8, LANES=6, IMMUNE_TICKS=3, LIVES=3, START_POS=2)
REQ-033 attempt_move=10 cycle 2, then 01 cycle 4, rows clear -> tick 1: move_result 10, position 3; the 01 request is ignored.
REQ-034 position 5, attempt_move=10, next_row=6'b100000 -> move_result 11, position 5, lives 2, immune 1.
REQ-035 After a hit, next_row=6'b111111 for 3 ticks -> no hits, lives stay 2; immune drops on the 3rd tick; 4th tick -> hit, lives 1.
REQ-036 Three hits separated by immunity -> lives 0, game_over 1; further ticks produce no result_valid; rst -> lives 3, position 2.
REQ-037 attempt_move=01 on the tick cycle only -> that tick reports 00; the next tick reports 01, position 1.
REQ-038 rst pulsed on a tick cycle during IMMUNE -> no result_valid, immune 0, all outputs at reset values next cycle.
